// File: rtl/payload_reader_pkg.sv
// Shared state type and descriptor-length helpers for payload_stream_reader.
// Fallback widths are supplied here when the build does not define them.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_WIDTH_B
`define BUS_WIDTH_B 4
`endif
`ifndef MAX_PAYLOAD_LEN
`define MAX_PAYLOAD_LEN 2048
`endif

package payload_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Byte length limited to the capacity of one slot (2^addr_w words).
  function automatic logic [32:0] clamp_len(input logic [31:0] len,
                                            input int bytes,
                                            input int addr_w);
    logic [32:0] cap;
    cap = 33'(bytes) << addr_w;
    return ({1'b0, len} > cap) ? cap : {1'b0, len};
  endfunction

  function automatic logic [32:0] words_of(input logic [31:0] len,
                                           input int bytes,
                                           input int addr_w);
    logic [32:0] c;
    c = clamp_len(len, bytes, addr_w);
    return (c + 33'(bytes - 1)) / 33'(bytes);
  endfunction

  // Tail-beat byte mask; a length that fills the final word keeps every byte.
  function automatic logic [63:0] last_keep(input logic [32:0] len,
                                            input int bytes);
    logic [32:0] rem;
    rem = len % 33'(bytes);
    if (rem == 33'd0) return '1;
    return (64'd1 << rem) - 64'd1;
  endfunction

endpackage

// File: rtl/payload_skid_buf.sv
// Two-entry valid/ready buffer for {data, keep, last}; exposes its occupancy
// so the reader can meter reads against free space.
module payload_skid_buf
  import payload_reader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [KEEP_W-1:0] push_keep,
  input  logic              push_last,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] data_q [2];
  logic [KEEP_W-1:0] keep_q [2];
  logic              last_q [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        occ;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= push_data;
      keep_q[wr_ptr] <= push_keep;
      last_q[wr_ptr] <= push_last;
    end
  end

  // Outputs read as zero while empty so the stream is clean out of reset.
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? data_q[rd_ptr] : '0;
  assign out_keep  = out_valid ? keep_q[rd_ptr] : '0;
  assign out_last  = out_valid ? last_q[rd_ptr] : 1'b0;
  assign occupancy = occ;

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && occ == 2'd2));
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset)
    !(pop && occ == 2'd0));

endmodule

// File: rtl/payload_stream_reader.sv
// Drains one payload slot per descriptor into a valid/ready byte stream.
// Optional packet/byte counters are enabled by PAYLOAD_READER_STATS_EN.
module payload_stream_reader
  import payload_reader_pkg::*;
#(
  parameter int BUS_WIDTH  = `BUS_WIDTH,
  parameter int BYTES      = `BUS_WIDTH_B,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = $clog2(`MAX_PAYLOAD_LEN / 4),
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ID_WIDTH-1:0]   desc_id,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  output logic                  rd_en,
  output logic [ID_WIDTH-1:0]   rd_id,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BUS_WIDTH-1:0]  rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BUS_WIDTH-1:0]  m_data,
  output logic [BYTES-1:0]      m_keep,
  output logic                  m_last,
  output logic                  done_valid,
  output logic [ID_WIDTH-1:0]   done_id
`ifdef PAYLOAD_READER_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [31:0]           byte_count
`endif
);

  localparam int NW_W = LEN_WIDTH + 1;

  state_t                st;
  state_t                st_nxt;
  logic                  accept;
  logic                  pop;
  logic                  credit_ok;
  logic                  rd_last;
  logic [2:0]            pending;
  logic [1:0]            occupancy;
  logic [32:0]           clamped;
  logic [NW_W-1:0]       nwords_in;
  logic [BYTES-1:0]      tail_in;
  logic [ADDR_WIDTH-1:0] last_addr_in;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [BYTES-1:0]      tail_keep;

  logic                  vld_p0;
  logic [BYTES-1:0]      keep_p0;
  logic                  last_p0;

  assign clamped      = clamp_len(32'(desc_len), BYTES, ADDR_WIDTH);
  assign nwords_in    = NW_W'(words_of(32'(desc_len), BYTES, ADDR_WIDTH));
  assign tail_in      = BYTES'(last_keep(clamped, BYTES));
  assign last_addr_in = ADDR_WIDTH'(nwords_in - NW_W'(1));

  assign pop     = m_valid & m_ready;
  assign rd_last = (rd_addr == last_addr);
  // Words buffered plus the one in flight, net of this cycle's pop, must
  // leave a free entry for the word a new read would return.
  assign pending   = 3'(occupancy) + 3'(vld_p0) - 3'(pop);
  assign credit_ok = (pending < 3'd2);
  assign accept    = desc_valid & desc_ready;

  always_ff @(posedge CLK) begin
    if (!reset) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt     = st;
    desc_ready = 1'b0;
    rd_en      = 1'b0;
    case (st)
      IDLE: begin
        desc_ready = reset;
        if (desc_valid && reset && nwords_in != '0) st_nxt = READ;
      end
      READ: begin
        rd_en = credit_ok;
        if (credit_ok && rd_last) st_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      rd_id      <= '0;
      rd_addr    <= '0;
      vld_p0     <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      vld_p0     <= rd_en;
      done_valid <= 1'b0;
      if (accept) begin
        rd_id   <= desc_id;
        rd_addr <= '0;
        if (nwords_in == '0) begin
          done_valid <= 1'b1;
          done_id    <= desc_id;
        end
      end else if (rd_en && !rd_last) begin
        rd_addr <= rd_addr + 1'b1;
      end
      if (pop && m_last) begin
        done_valid <= 1'b1;
        done_id    <= rd_id;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      last_addr <= last_addr_in;
      tail_keep <= tail_in;
    end
  end

  // ---- p0: side-band for the read in flight, aligned with rd_data ----
  always_ff @(posedge CLK) begin
    if (rd_en) begin
      keep_p0 <= rd_last ? tail_keep : '1;
      last_p0 <= rd_last;
    end
  end

  payload_skid_buf #(
    .DATA_W (BUS_WIDTH),
    .KEEP_W (BYTES)
  ) u_skid (
    .clk       (CLK),
    .reset     (reset),
    .push      (vld_p0),
    .push_data (rd_data),
    .push_keep (keep_p0),
    .push_last (last_p0),
    .pop       (pop),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_keep  (m_keep),
    .out_last  (m_last),
    .occupancy (occupancy)
  );

`ifdef PAYLOAD_READER_STATS_EN
  logic [NW_W-1:0] len_q;

  always_ff @(posedge CLK) begin
    if (accept) len_q <= NW_W'(clamped);
  end

  // done_valid fires before any later accept can overwrite len_q.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else if (done_valid) begin
      pkt_count  <= pkt_count + 32'd1;
      byte_count <= byte_count + 32'(len_q);
    end
  end
`endif

endmodule

// File: tb/tb_payload_stream_reader.sv
// Self-checking bench for payload_stream_reader with a slot-memory model and
// a queue-based reference of the expected stream.
module tb_payload_stream_reader;

  logic        CLK;
  logic        reset;
  logic        desc_valid;
  logic        desc_ready;
  logic [3:0]  desc_id;
  logic [15:0] desc_len;
  logic        rd_en;
  logic [3:0]  rd_id;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        done_valid;
  logic [3:0]  done_id;
`ifdef PAYLOAD_READER_STATS_EN
  logic [31:0] pkt_count;
  logic [31:0] byte_count;
`endif

  payload_stream_reader #(
    .BUS_WIDTH  (32),
    .BYTES      (4),
    .ID_WIDTH   (4),
    .ADDR_WIDTH (4),
    .LEN_WIDTH  (16)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_id    (desc_id),
    .desc_len   (desc_len),
    .rd_en      (rd_en),
    .rd_id      (rd_id),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .done_valid (done_valid),
    .done_id    (done_id)
`ifdef PAYLOAD_READER_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .byte_count (byte_count)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]  id;
    logic [15:0] len;
    int          beats;
    logic [3:0]  lkeep;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mode     = 0;
  logic [31:0] mem [16][16];
  beat_t       exp_q [$];

  logic [3:0]  cur_id;
  int          exp_raddr, exp_nwords;
  bit          exp_done_next;
  logic [3:0]  exp_done_id;
  int          issued, popped;
  int          acc_cyc, first_cyc, last_cyc, rd_first_cyc, beats_seen;
  logic [3:0]  keep_seen;
  bit          stall_prev;
  beat_t       stall_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: slot capacity is 16 words of 4 bytes.
  function automatic int model_words(input int len);
    int l;
    l = (len > 64) ? 64 : len;
    return (l + 3) / 4;
  endfunction

  function automatic logic [3:0] model_keep(input int len);
    int l;
    int r;
    l = (len > 64) ? 64 : len;
    r = l % 4;
    return (r == 0) ? 4'hF : 4'((1 << r) - 1);
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Slot memory: data appears one cycle after the strobe, junk otherwise.
  initial begin
    bit         p;
    logic [3:0] pid;
    logic [3:0] pa;
    rd_data = '0;
    forever begin
      @(negedge CLK);
      p   = rd_en;
      pid = rd_id;
      pa  = rd_addr;
      @(posedge CLK);
      #1;
      rd_data = p ? mem[pid][pa] : $urandom;
    end
  end

  initial begin
    int ph;
    ph = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = (ph % 4 == 0) || (ph % 4 == 3);
          ph++;
        end
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor and scoreboard.
  always @(negedge CLK) begin
    beat_t b;
    int    n;
    if (!reset) begin
      exp_q.delete();
      exp_done_next = 0;
      issued        = 0;
      popped        = 0;
      stall_prev    = 0;
    end else begin
      check("done_valid", done_valid, exp_done_next);
      if (exp_done_next) check("done_id", done_id, exp_done_id);
      exp_done_next = 0;

      if (desc_valid && desc_ready) begin
        n          = model_words(int'(desc_len));
        cur_id     = desc_id;
        exp_raddr  = 0;
        exp_nwords = n;
        acc_cyc    = cyc;
        beats_seen = 0;
        for (int k = 0; k < n; k++) begin
          b.data = mem[desc_id][k];
          b.last = (k == n - 1);
          b.keep = b.last ? model_keep(int'(desc_len)) : 4'hF;
          exp_q.push_back(b);
        end
        if (n == 0) begin
          exp_done_next = 1;
          exp_done_id   = desc_id;
        end
      end

      if (rd_en) begin
        check("rd_id", rd_id, cur_id);
        check("rd_addr", rd_addr, 64'(exp_raddr));
        check("rd_in_range", exp_raddr < exp_nwords, 1);
        if (exp_raddr == 0) rd_first_cyc = cyc;
        exp_raddr++;
        issued++;
      end

      if (stall_prev) begin
        check("stall_valid", m_valid, 1);
        check("stall_beat", {m_data, m_keep, m_last}, stall_beat);
      end

      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", m_data, b.data);
          check("beat_keep", m_keep, b.keep);
          check("beat_last", m_last, b.last);
          if (beats_seen == 0) first_cyc = cyc;
          beats_seen++;
          if (b.last) begin
            last_cyc      = cyc;
            keep_seen     = m_keep;
            exp_done_next = 1;
            exp_done_id   = cur_id;
          end
        end
        popped++;
      end

      if (rd_en) check("outstanding_le_2", (issued - popped) <= 2, 1);

      stall_prev = m_valid && !m_ready;
      stall_beat = {m_data, m_keep, m_last};
    end
  end

  task automatic send_desc(input logic [3:0] id, input logic [15:0] len);
    bit got;
    got = 0;
    @(posedge CLK);
    #1;
    desc_id    = id;
    desc_len   = len;
    desc_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (desc_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    desc_valid = 1'b0;
    check("desc_accepted", got, 1);
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (done_valid) begin
        got = 1;
        break;
      end
    end
    check("done_seen", got, 1);
  endtask

  task automatic run_pkt(input logic [3:0] id, input logic [15:0] len,
                         input int beats, input logic [3:0] lkeep, input bit timed);
    send_desc(id, len);
    wait_done();
    check("beat_count", 64'(beats_seen), 64'(beats));
    if (beats > 0) check("tail_keep", keep_seen, lkeep);
    if (timed && beats > 0) begin
      check("first_rd_latency", 64'(rd_first_cyc - acc_cyc), 1);
      check("first_beat_latency", 64'(first_cyc - acc_cyc), 3);
      check("no_bubbles", 64'(last_cyc - first_cyc), 64'(beats - 1));
    end
  endtask

  initial begin
    vec_t tbl [8];
    tbl[0] = '{4'd3, 16'd10,     3,  4'h3};
    tbl[1] = '{4'd1, 16'd8,      2,  4'hF};
    tbl[2] = '{4'd5, 16'd0,      0,  4'h0};
    tbl[3] = '{4'd2, 16'hFFFF,   16, 4'hF};
    tbl[4] = '{4'd7, 16'd5,      2,  4'h1};
    tbl[5] = '{4'd4, 16'd64,     16, 4'hF};
    tbl[6] = '{4'd6, 16'd65,     16, 4'hF};
    tbl[7] = '{4'd9, 16'd1,      1,  4'h1};

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        mem[i][j] = $urandom;

    reset      = 1'b0;
    desc_valid = 1'b0;
    desc_id    = '0;
    desc_len   = '0;
    mode       = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_desc_ready", desc_ready, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_id", rd_id, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_last", m_last, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_id", done_id, 0);
    #1 reset = 1'b1;
    @(negedge CLK);
    check("desc_ready_after_reset", desc_ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_pkt(tbl[i].id, tbl[i].len, tbl[i].beats, tbl[i].lkeep, 1'b1);
`ifdef PAYLOAD_READER_STATS_EN
      if (i == 2) begin
        check("pkt_count", pkt_count, 3);
        check("byte_count", byte_count, 18);
      end
`endif
    end

    // 1,0,0,1 backpressure across a 10-word packet.
    mode = 1;
    run_pkt(4'hA, 16'd40, 10, 4'hF, 1'b0);

    // Full stall: reads must stop once two words are committed.
    mode = 3;
    send_desc(4'hB, 16'd40);
    repeat (8) @(negedge CLK);
    check("stall_outstanding", 64'(issued - popped), 2);
    check("stall_m_valid", m_valid, 1);
    mode = 0;
    wait_done();
    check("stall_beat_count", 64'(beats_seen), 10);

    // Reset in the middle of a 10-word packet.
    send_desc(4'h2, 16'd40);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (rd_en && rd_addr == 4'd3) break;
    end
    #1 reset = 1'b0;
    @(negedge CLK);
    check("mid_rst_desc_ready", desc_ready, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_rd_id", rd_id, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_m_keep", m_keep, 0);
    check("mid_rst_m_last", m_last, 0);
    check("mid_rst_done_valid", done_valid, 0);
    check("mid_rst_done_id", done_id, 0);
    #1 reset = 1'b1;
    @(negedge CLK);
    check("ready_after_mid_rst", desc_ready, 1);
    repeat (4) @(negedge CLK);
    run_pkt(4'h8, 16'd4, 1, 4'hF, 1'b1);

    // Randomized descriptors under random backpressure.
    mode = 2;
    for (int i = 0; i < 25; i++) begin
      logic [3:0]  rid;
      logic [15:0] rlen;
      rid  = 4'($urandom_range(0, 15));
      rlen = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 90));
      run_pkt(rid, rlen, model_words(int'(rlen)), model_keep(int'(rlen)), 1'b0);
    end
    mode = 0;
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
